// File: rtl/vex_input_framer_if.sv
// Stream bundle between the sample source, the framer and the vex machine t0 input.
//   in_data / in_valid          : free-running sample stream. It has no ready, so the source can never stall.
//   t0_data / t0_last / t0_valid: framed output words. t0_last marks the final word of each frame.
//   t0_ready                    : the downstream consumer accepts the current word.
// Handshake: a t0 word transfers on a clock edge where t0_valid && t0_ready. While t0_valid is high
// and t0_ready is low, t0_data and t0_last hold steady. The in_* side carries no handshake.
// Modports: slave = framer side, master = source/consumer side.
interface vex_input_framer_if #(
  parameter int WIDTH = 32
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic [WIDTH-1:0] t0_data;
  logic             t0_last;
  logic             t0_valid;
  logic             t0_ready;

  modport slave (
    input  in_data, in_valid, t0_ready,
    output t0_data, t0_last, t0_valid
  );

  modport master (
    output in_data, in_valid, t0_ready,
    input  t0_data, t0_last, t0_valid
  );
endinterface

// File: rtl/vex_input_framer.sv
// Cuts a free-running sample stream into FRAME_LEN-word frames and buffers them in a store-ahead FIFO
// with a first-word-fall-through output register. A frame is either admitted whole or dropped whole.
// Dropped frames are counted in a saturating counter.
// Ports:
//   clk, reset_n : single clock domain. Reset asserts asynchronously and is active low.
//   enable       : admits new frames. It is sampled only on the first beat of a frame.
//   clr_drops    : synchronous clear of drop_count. It wins over a simultaneous increment.
//   bus          : in_* sample stream and t0_* framed output (see vex_input_framer_if).
//   drop_count   : number of frames discarded, saturating at all-ones.
//   state_dbg    : encoding of the write-side FSM state (0 IDLE, 1 ACCEPT, 2 DROP).
module vex_input_framer #(
  parameter int WIDTH      = 32,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 2048
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                clr_drops,
  vex_input_framer_if.slave   bus,
  output logic [31:0]         drop_count,
  output logic [1:0]          state_dbg
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  // A frame may start only if FIFO_DEPTH - occupancy >= FRAME_LEN.
  localparam logic [OCC_W-1:0] ADMIT_MAX = OCC_W'(FIFO_DEPTH - FRAME_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  // Occupancy counts the words in storage plus a loaded output register.
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic [31:0]      drop_q, drop_d;

  // Each storage entry holds the last tag above the data word.
  logic [WIDTH:0]   mem_q [FIFO_DEPTH];

  logic             push, push_last, drop_inc, pop, load, has_room;
  logic [OCC_W-1:0] mem_count;

  assign pop       = out_valid_q & bus.t0_ready;
  assign mem_count = occ_q - OCC_W'(out_valid_q);
  // Refill the output register when it is empty or when it is being emptied this cycle.
  assign load      = (mem_count != '0) & (~out_valid_q | bus.t0_ready);
  // The pop of the current cycle is not credited to the admission decision.
  assign has_room  = (occ_q <= ADMIT_MAX);

  // Write-side FSM. The frame decision is taken on the in_valid beat where idx is 0.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    push      = 1'b0;
    push_last = 1'b0;
    drop_inc  = 1'b0;
    if (bus.in_valid) begin
      case (state_q)
        S_IDLE: begin
          // enable low: discard the sample and keep idx at 0, so every later beat is a new boundary.
          if (enable) begin
            idx_d = IDX_W'(1);
            if (has_room) begin
              push    = 1'b1;
              state_d = S_ACCEPT;
            end else begin
              drop_inc = 1'b1;
              state_d  = S_DROP;
            end
          end
        end
        S_ACCEPT: begin
          push = 1'b1;
          if (idx_q == LAST_IDX) begin
            push_last = 1'b1;
            idx_d     = '0;
            state_d   = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_DROP: begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: begin
          idx_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy, output register and drop counter.
  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d    = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = mem_q[rd_ptr_q][WIDTH-1:0];
      out_last_d  = mem_q[rd_ptr_q][WIDTH];
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
    occ_d = occ_q;
    if (push && !pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push && pop) begin
      occ_d = occ_q - OCC_W'(1);
    end
    drop_d = drop_q;
    if (clr_drops) begin
      drop_d = '0;
    end else if (drop_inc && (drop_q != 32'hFFFF_FFFF)) begin
      drop_d = drop_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      drop_q      <= drop_d;
    end
  end

  // Storage needs no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {push_last, bus.in_data};
    end
  end

  // Admission reserves a whole frame of space, so a write into a full FIFO is never expected.
  assert property (@(posedge clk) disable iff (!reset_n)
    !(push && (occ_q == OCC_W'(FIFO_DEPTH))));

  assign bus.t0_valid = out_valid_q;
  assign bus.t0_data  = out_data_q;
  assign bus.t0_last  = out_last_q;
  assign drop_count   = drop_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_vex_input_framer.sv
// Directed bench for vex_input_framer with FRAME_LEN=4 and FIFO_DEPTH=8.
module tb_vex_input_framer;
  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        clr_drops;
  logic [31:0] drop_count;
  logic [1:0]  state_dbg;

  vex_input_framer_if #(.WIDTH(32)) bus ();

  vex_input_framer #(.WIDTH(32), .FRAME_LEN(4), .FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .clr_drops  (clr_drops),
    .bus        (bus),
    .drop_count (drop_count),
    .state_dbg  (state_dbg)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  logic [32:0] obs_q[$];

  // Record every word that transfers, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.t0_valid === 1'b1 && bus.t0_ready === 1'b1)
      obs_q.push_back({bus.t0_last, bus.t0_data});
  end

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected words a..b, last on every fourth word counted from a.
  task automatic add_exp(input int a, input int b);
    for (int v = a; v <= b; v++) exp_q.push_back({((v - a) % 4) == 3, 32'(v)});
  endtask

  task automatic push(input int d);
    bus.in_data  = 32'(d);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic push_range(input int a, input int b);
    for (int v = a; v <= b; v++) push(v);
  endtask

  task automatic drain(input int n);
    bus.t0_ready = 1'b1;
    for (int c = 0; c < 200 && obs_q.size() < n; c++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag);
    int n;
    check({tag, "_count"}, 33'(obs_q.size()), 33'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_word%0d", tag, i), obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    enable       = 1'b1;
    clr_drops    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.t0_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    obs_q.delete();
    exp_q.delete();
  endtask

  int          next_v;
  logic        prev_stall;
  logic [31:0] prev_d;
  logic        prev_l;

  initial begin
    do_reset();
    check("rst_valid", 33'(bus.t0_valid), 33'(0));
    check("rst_last",  33'(bus.t0_last),  33'(0));
    check("rst_data",  33'(bus.t0_data),  33'(0));
    check("rst_drops", 33'(drop_count),   33'(0));
    check("rst_state", 33'(state_dbg),    33'(0));

    // 1: two frames straight through, two-cycle latency.
    push(1);
    check("t1_lat_n",  33'(bus.t0_valid), 33'(0));
    push(2);
    check("t1_lat_n1", 33'(bus.t0_valid), 33'(1));
    check("t1_first",  33'(bus.t0_data),  33'(1));
    push_range(3, 8);
    add_exp(1, 8);
    drain(8);
    check_stream("t1");
    check("t1_drops", 33'(drop_count), 33'(0));

    // 2: no readiness, third frame does not fit.
    do_reset();
    bus.t0_ready = 1'b0;
    push_range(1, 12);
    check("t2_drops", 33'(drop_count),   33'(1));
    check("t2_hold",  33'(bus.t0_data),  33'(1));
    check("t2_state", 33'(state_dbg),    33'(0));
    add_exp(1, 8);
    drain(8);
    check_stream("t2");

    // 3: one pop before the third frame still leaves too little room.
    do_reset();
    bus.t0_ready = 1'b0;
    push_range(1, 8);
    bus.t0_ready = 1'b1;
    @(posedge clk); #1;
    bus.t0_ready = 1'b0;
    push_range(9, 12);
    check("t3_drops", 33'(drop_count), 33'(1));
    add_exp(1, 8);
    drain(8);
    check_stream("t3");

    // 4: enable falls mid-frame; only the next boundary is gated.
    do_reset();
    push_range(1, 2);
    enable = 1'b0;
    push_range(3, 8);
    add_exp(1, 4);
    drain(4);
    check_stream("t4");
    check("t4_drops", 33'(drop_count), 33'(0));
    check("t4_state", 33'(state_dbg),  33'(0));

    // 5: random stalls and input gaps.
    do_reset();
    next_v = 1;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    for (int c = 0; c < 400 && obs_q.size() < 8; c++) begin
      bus.t0_ready = 1'($urandom_range(0, 1));
      if (next_v <= 8 && $urandom_range(0, 2) != 0) begin
        bus.in_data  = 32'(next_v);
        bus.in_valid = 1'b1;
        next_v++;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      if (prev_stall) begin
        check("t5_stall_valid", 33'(bus.t0_valid), 33'(1));
        check("t5_stall_data",  33'(bus.t0_data),  33'(prev_d));
        check("t5_stall_last",  33'(bus.t0_last),  33'(prev_l));
      end
      prev_stall = bus.t0_valid & ~bus.t0_ready;
      prev_d     = bus.t0_data;
      prev_l     = bus.t0_last;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    add_exp(1, 8);
    drain(8);
    check_stream("t5");

    // 5b: clear coinciding with a drop event leaves zero.
    bus.t0_ready = 1'b0;
    push_range(9, 16);
    clr_drops = 1'b1;
    push(17);
    clr_drops = 1'b0;
    check("t5_clr", 33'(drop_count), 33'(0));
    push_range(18, 20);
    check("t5_clr_hold", 33'(drop_count), 33'(0));
    push_range(21, 24);
    check("t5_inc", 33'(drop_count), 33'(1));
    add_exp(9, 16);
    drain(8);
    check_stream("t5b");

    // 6: reset mid-frame.
    do_reset();
    bus.t0_ready = 1'b0;
    push_range(1, 2);
    reset_n = 1'b0;
    #1;
    check("t6_valid", 33'(bus.t0_valid), 33'(0));
    check("t6_last",  33'(bus.t0_last),  33'(0));
    check("t6_data",  33'(bus.t0_data),  33'(0));
    check("t6_drops", 33'(drop_count),   33'(0));
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    obs_q.delete();
    exp_q.delete();
    bus.t0_ready = 1'b1;
    push_range(10, 13);
    add_exp(10, 13);
    drain(4);
    check_stream("t6");
    check("t6_drops_after", 33'(drop_count), 33'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
